// File: rtl/gcd_ctrl.sv
// Controller FSM for the subtractive GCD datapath: start/busy/done handshake,
// operand load strobe, iteration counting with timeout, and error reporting.
module gcd_ctrl #(
  parameter int unsigned ITER_W   = 9,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_zero,
  input  logic [1:0]        stat,
  output logic              load,
  output logic [1:0]        cmd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIN,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_SUB_A = 2'd1,
    CMD_SUB_B = 2'd2,
    CMD_LATCH = 2'd3
  } cmd_t;

  localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;
  cmd_t              cmd_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cmd_c   = CMD_NOP;
    case (state_q)
      IDLE: begin
        if (start) begin
          iter_d = '0;
          // a zero operand skips the datapath entirely; err is set on ERR entry
          if (op_zero) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
            err_d   = 1'b0;
          end
        end
      end
      LOAD: begin
        load    = 1'b1;
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        case (stat)
          2'd0: begin
            cmd_c   = CMD_LATCH;
            state_d = FIN;
          end
          2'd1, 2'd2: begin
            if (iter_q < MAX_ITER_V) begin
              cmd_c  = (stat == 2'd1) ? CMD_SUB_A : CMD_SUB_B;
              iter_d = iter_q + ITER_W'(1);
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
          default: begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        endcase
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd  = cmd_c;
  assign err  = err_q;
  assign iter = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl: two instances (MAX_ITER 255 and 4), each
// driven by a behavioural 8-bit subtractive datapath model.
module tb_gcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start_w;
  logic       op_zero;
  logic [7:0] x_in, y_in;
  logic       force3;

  logic [1:0] load_w, busy_w, done_w, err_w;
  logic [1:0] cmd_w  [2];
  logic [1:0] stat_w [2];
  logic [8:0] iter_w [2];

  logic [7:0] a_m [2];
  logic [7:0] b_m [2];
  logic [1:0] ld_m;

  always #5 clk = ~clk;

  gcd_ctrl #(.ITER_W(9), .MAX_ITER(255)) dut (
    .clk(clk), .reset(reset), .start(start_w[0]), .op_zero(op_zero),
    .stat(stat_w[0]), .load(load_w[0]), .cmd(cmd_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .err(err_w[0]), .iter(iter_w[0])
  );

  gcd_ctrl #(.ITER_W(9), .MAX_ITER(4)) dut_to (
    .clk(clk), .reset(reset), .start(start_w[1]), .op_zero(op_zero),
    .stat(stat_w[1]), .load(load_w[1]), .cmd(cmd_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .err(err_w[1]), .iter(iter_w[1])
  );

  // behavioural datapath
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        ld_m[d] <= 1'b0;
      end else if (load_w[d]) begin
        a_m[d]  <= x_in;
        b_m[d]  <= y_in;
        ld_m[d] <= 1'b1;
      end else if (cmd_w[d] == 2'd1) begin
        a_m[d] <= a_m[d] - b_m[d];
      end else if (cmd_w[d] == 2'd2) begin
        b_m[d] <= b_m[d] - a_m[d];
      end
    end
  end

  function automatic logic [1:0] stat_of(input logic ld, input logic [7:0] a, input logic [7:0] b);
    if (!ld)        return 2'd3;
    else if (a == b) return 2'd0;
    else if (a > b)  return 2'd1;
    else             return 2'd2;
  endfunction

  assign stat_w[0] = force3 ? 2'd3 : stat_of(ld_m[0], a_m[0], b_m[0]);
  assign stat_w[1] = force3 ? 2'd3 : stat_of(ld_m[1], a_m[1], b_m[1]);

  typedef struct {
    int dut;
    int iter;
    int err;
    int lat;
    int loads;
    int n1;
    int n2;
    int n3;
  } rec_t;

  rec_t exp_q[$];
  rec_t r;
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int d, input logic [7:0] x, input logic [7:0] y, input bit push,
                    input int e_iter, input int e_err, input int e_lat, input int e_loads,
                    input int e_n1, input int e_n2, input int e_n3);
    rec_t e;
    x_in    = x;
    y_in    = y;
    op_zero = (x == 8'd0) || (y == 8'd0);
    if (push) begin
      e = '{d, e_iter, e_err, e_lat, e_loads, e_n1, e_n2, e_n3};
      exp_q.push_back(e);
    end
    start_w[d] = 1'b1;
    tick();
    start_w[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int seen;
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      if (done_w[d]) seen = 1;
      tick();
    end
    check("done_within_budget", seen, 1);
  endtask

  // monitor: tracks each run from first busy/done cycle to the done pulse
  int act [2];
  int cyc [2];
  int nld [2];
  int c1  [2];
  int c2  [2];
  int c3  [2];
  int bl  [2];

  initial begin
    act = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          act[d] = 0;
        end else begin
          check("load_cmd_exclusive", int'(load_w[d] && cmd_w[d] != 2'd0), 0);
          check("cmd_nop_when_idle", int'(!busy_w[d] && cmd_w[d] != 2'd0), 0);
          if (act[d] == 0 && (busy_w[d] || done_w[d])) begin
            act[d] = 1; cyc[d] = 0; nld[d] = 0;
            c1[d] = 0; c2[d] = 0; c3[d] = 0; bl[d] = 0;
          end
          if (act[d] != 0) begin
            cyc[d]++;
            if (load_w[d]) nld[d]++;
            if (cmd_w[d] == 2'd1) c1[d]++;
            if (cmd_w[d] == 2'd2) c2[d]++;
            if (cmd_w[d] == 2'd3) c3[d]++;
            if (!done_w[d] && !busy_w[d]) bl[d]++;
            if (done_w[d]) begin
              act[d] = 0;
              check("pending_expectation", int'(exp_q.size() > 0), 1);
              if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("run_dut", d, r.dut);
                check("iter", int'(iter_w[d]), r.iter);
                check("err", int'(err_w[d]), r.err);
                check("done_latency", cyc[d], r.lat);
                check("load_count", nld[d], r.loads);
                check("cmd1_count", c1[d], r.n1);
                check("cmd2_count", c2[d], r.n2);
                check("cmd3_count", c3[d], r.n3);
                check("busy_gaps", bl[d], 0);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    start_w = 2'b00;
    op_zero = 1'b0;
    x_in    = 8'd0;
    y_in    = 8'd0;
    force3  = 1'b0;
    repeat (3) tick();
    check("rst_load", int'(load_w[0]), 0);
    check("rst_cmd", int'(cmd_w[0]), 0);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    check("rst_err", int'(err_w[0]), 0);
    check("rst_iter", int'(iter_w[0]), 0);
    reset = 1'b0;
    tick();

    // 12/18 with a start pulse during RUN that must be ignored
    go(0, 8'd12, 8'd18, 1'b1, 2, 0, 5, 1, 1, 1, 1);
    tick();
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    wait_done(0);

    go(0, 8'd7, 8'd7, 1'b1, 0, 0, 3, 1, 0, 0, 1);
    wait_done(0);

    go(0, 8'd255, 8'd1, 1'b1, 254, 0, 257, 1, 254, 0, 1);
    wait_done(0);

    // timeout on the MAX_ITER=4 instance, then recovery
    go(1, 8'd255, 8'd1, 1'b1, 4, 1, 7, 1, 4, 0, 0);
    wait_done(1);
    check("err_sticky_idle", int'(err_w[1]), 1);
    go(1, 8'd12, 8'd18, 1'b1, 2, 0, 5, 1, 1, 1, 1);
    check("err_cleared_on_start", int'(err_w[1]), 0);
    wait_done(1);

    // zero operand: straight to ERR, no load
    go(0, 8'd0, 8'd9, 1'b1, 0, 1, 1, 0, 0, 0, 0);
    wait_done(0);

    // invalid status forced after one subtract step
    go(0, 8'd12, 8'd18, 1'b1, 1, 1, 4, 1, 0, 1, 0);
    tick();
    tick();
    force3 = 1'b1;
    wait_done(0);
    force3 = 1'b0;

    // reset after three subtract steps
    go(0, 8'd255, 8'd1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("iter_before_reset", int'(iter_w[0]), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_rst_load", int'(load_w[0]), 0);
    check("midrun_rst_cmd", int'(cmd_w[0]), 0);
    check("midrun_rst_busy", int'(busy_w[0]), 0);
    check("midrun_rst_done", int'(done_w[0]), 0);
    check("midrun_rst_err", int'(err_w[0]), 0);
    check("midrun_rst_iter", int'(iter_w[0]), 0);
    tick();

    go(0, 8'd7, 8'd7, 1'b1, 0, 0, 3, 1, 0, 0, 1);
    wait_done(0);

    repeat (3) tick();
    check("expectations_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
